// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status encodings and the
// PC-update FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic [1:0] {
        S_AOK = 2'b00,
        S_HLT = 2'b01,
        S_ADR = 2'b10,
        S_INS = 2'b11
    } pc_state_e;

    function automatic logic [1:0] stat_of(input pc_state_e s);
        case (s)
            S_AOK:   return STAT_AOK;
            S_HLT:   return STAT_HLT;
            S_ADR:   return STAT_ADR;
            default: return STAT_INS;
        endcase
    endfunction

endpackage

// File: rtl/pc_update_ctrl_new_pc_sel.sv
// Combinational Y86-64 SEQ new-PC multiplexer (call/taken jxx -> valC,
// ret -> valM, everything else falls through to valP).
module new_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] npc
);

    always_comb begin
        npc = valP;
        case (icode)
            I_CALL:  npc = valC;
            I_JXX:   npc = cnd ? valC : valP;
            I_RET:   npc = valM;
            default: npc = valP;
        endcase
    end

endmodule

// File: rtl/pc_update_ctrl.sv
// Architectural PC and status register for a Y86-64 SEQ core.
// Optional macro PC_STATS_EN adds saturating instruction / taken-branch counters.
module pc_update_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    input  logic        hlt,
    output logic [63:0] pc,
    output logic [1:0]  stat,
    output logic        running
`ifdef PC_STATS_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] br_taken_cnt
`endif
);

    pc_state_e   state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] sel_pc;

    new_pc_sel u_new_pc_sel (
        .icode (icode),
        .cnd   (cnd),
        .valC  (valC),
        .valP  (valP),
        .valM  (valM),
        .npc   (sel_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_AOK;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Error checks are strictly ordered; the PC only moves on an accepted commit.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == S_AOK && commit) begin
            if (imem_error) begin
                state_d = S_ADR;
            end else if (!instr_valid) begin
                state_d = S_INS;
            end else if (dmem_error) begin
                state_d = S_ADR;
            end else if (hlt || icode == I_HALT) begin
                state_d = S_HLT;
                pc_d    = valP;
            end else if (sel_pc >= 64'(IMEM_DEPTH)) begin
                state_d = S_ADR;
            end else begin
                pc_d    = sel_pc;
            end
        end
    end

    always_comb begin
        pc      = pc_q;
        stat    = stat_of(state_q);
        running = (state_q == S_AOK);
    end

`ifdef PC_STATS_EN
    logic        accept;
    logic        taken;
    logic [31:0] instr_cnt_q;
    logic [31:0] br_taken_cnt_q;

    // Accepted commits are exactly those leaving S_AOK for S_AOK or S_HLT.
    assign accept = (state_q == S_AOK) && commit &&
                    (state_d == S_AOK || state_d == S_HLT);
    assign taken  = accept && (state_d == S_AOK) &&
                    ((icode == I_JXX && cnd) || icode == I_CALL || icode == I_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q    <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            if (accept && instr_cnt_q != 32'hFFFF_FFFF)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (taken && br_taken_cnt_q != 32'hFFFF_FFFF)
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
        end
    end

    assign instr_cnt    = instr_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: doc/pc_update_ctrl.md
Name: pc_update_ctrl

Overview:
- Upstream neighbour of the SEQ fetch stage. Owns the architectural PC register and the processor status register.
- On each commit, computes the next PC from fetch/execute/memory results using the Y86-64 SEQ new-PC rules.
- Detects halt, invalid-instruction and address-error conditions, then freezes the PC and reports status.
- Sits between the write-back of instruction N and the fetch of instruction N+1.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_DEPTH, 1024, instruction memory size in bytes. A next PC >= IMEM_DEPTH raises ADR.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- commit  in  1  single-cycle pulse: the current instruction has completed all stages and its inputs are valid.
- icode  in  4  opcode of the current instruction.
- cnd  in  1  condition result from execute (jxx taken).
- valC  in  64  constant/destination word from fetch.
- valP  in  64  fall-through PC from fetch.
- valM  in  64  word read by memory (return address for ret).
- instr_valid  in  1  fetch decoded a legal icode.
- imem_error  in  1  fetch address out of range.
- dmem_error  in  1  data memory address error.
- hlt  in  1  fetch saw halt.
- pc  out  64  current PC, fed to fetch.
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
- running  out  1  high while stat==AOK.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, stat=AOK, running=1.
  - Optional counters clear to 0.
  - Reset asserted mid-operation aborts any pending commit. First commit after release uses pc=RESET_PC.
- FSM states: S_AOK, S_HLT, S_ADR, S_INS.
  - Terminal states leave only on reset.
  - stat is a registered encoding of the state. running = (state==S_AOK).
- In S_AOK, with commit=1, evaluate in strict priority order at the rising edge:
  1. imem_error -> S_ADR, pc unchanged.
  2. !instr_valid -> S_INS, pc unchanged.
  3. dmem_error -> S_ADR, pc unchanged.
  4. hlt or icode==0 -> S_HLT, pc=valP (Y86 convention: PC after halt points past it).
  5. Otherwise, new PC selection:
     - icode==8 (call) -> valC.
     - icode==7 and cnd -> valC.
     - icode==9 (ret) -> valM.
     - else valP.
  6. If the selected new PC >= IMEM_DEPTH -> S_ADR, pc unchanged. Otherwise pc takes the selected value and the state stays S_AOK.
- commit=0: no state or pc change.
- commit in a terminal state: ignored. pc and stat hold.
- Latency: pc and stat update one clock after the commit edge. Outputs are registered; there is no combinational path from inputs to outputs.
- Width: all PC arithmetic is 64-bit unsigned. No wrap detection beyond the IMEM_DEPTH compare. valP is trusted as produced by fetch.
- Simultaneous errors: the priority above is final, e.g. imem_error with dmem_error -> ADR; instr_valid=0 with hlt -> INS.

Optional Feature:
- PC_STATS_EN defined:
  - Adds outputs instr_cnt[31:0] and br_taken_cnt[31:0].
  - instr_cnt increments on every commit accepted in S_AOK, including the halting commit; it does not increment on commits that raise errors.
  - br_taken_cnt increments on committed taken jxx, call and ret.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT=0 … I_POPQ=4'hB).
  - stat encodings (STAT_AOK/HLT/ADR/INS).
  - FSM state typedef.
- One natural sub-module, new_pc_sel: purely combinational next-PC mux (icode, cnd, valC, valP, valM -> npc). It is instantiated once inside pc_update_ctrl.

Test Plan:
- Reset: rst_n low mid-run with pc=0x20, stat=HLT -> pc=RESET_PC=0, stat=00, running=1 immediately (asynchronous, before the next edge).
- Sequential flow: commit icode=3, valP=0x0C; then icode=4, valP=0x16 -> pc=0x0C, then 0x16, stat=AOK.
- Control flow:
  - jxx icode=7, cnd=0, valP=0x2B, valC=0x40 -> pc=0x2B.
  - Same with cnd=1 -> pc=0x40.
  - call valC=0x80 -> pc=0x80.
  - ret valM=0x2B -> pc=0x2B.
- Halt: commit icode=0, hlt=1, valP=0x21 -> pc=0x21, stat=01, running=0. A further commit with icode=1, valP=0x22 leaves pc=0x21.
- Errors:
  - commit with instr_valid=0 and dmem_error=1 -> stat=11, pc unchanged.
  - After reset, call valC=0x400 with IMEM_DEPTH=1024 -> stat=10, pc unchanged.
- PC_STATS_EN: 3 nops, 1 taken jxx, 1 not-taken jxx, then halt -> instr_cnt=6, br_taken_cnt=1. Counters freeze after halt.
